// File: rtl/ks_pkg.sv
// Shared constants, FSM encoding and directed vector table for the
// Kogge-Stone adder self-test block.
package ks_pkg;

  localparam int KS_W = 16;
  localparam int N_DIR = 12;
  localparam logic [KS_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [KS_W-1:0] a;
    logic [KS_W-1:0] b;
  } vec_t;

  function automatic vec_t dir_vec(input logic [3:0] i);
    vec_t v;
    v = '{a: 16'h0000, b: 16'h0000};
    case (i)
      4'd0:    v = '{a: 16'h0000, b: 16'h0000};
      4'd1:    v = '{a: 16'h0000, b: 16'h0001};
      4'd2:    v = '{a: 16'h0002, b: 16'h0005};
      4'd3:    v = '{a: 16'h000E, b: 16'h0001};
      4'd4:    v = '{a: 16'h000F, b: 16'h0001};
      4'd5:    v = '{a: 16'h0010, b: 16'h0001};
      4'd6:    v = '{a: 16'h0011, b: 16'h0005};
      4'd7:    v = '{a: 16'h000F, b: 16'h0000};
      4'd8:    v = '{a: 16'h0010, b: 16'h0000};
      4'd9:    v = '{a: 16'hFFFF, b: 16'h0001};
      4'd10:   v = '{a: 16'h7FFF, b: 16'h0001};
      4'd11:   v = '{a: 16'hFFFF, b: 16'hFFFF};
      default: v = '{a: 16'h0000, b: 16'h0000};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ks_lfsr.sv
// 16-bit Galois LFSR operand generator (right-shifting, taps LFSR_TAPS).
// Ports: clk, rst_n (async low), load (reload SEED), step (advance), q.
module ks_lfsr
  import ks_pkg::*;
#(
  parameter logic [KS_W-1:0] SEED = 16'h0001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  output logic [KS_W-1:0] q
);

  logic [KS_W-1:0] r_q;
  logic [KS_W-1:0] w_nxt;

  assign w_nxt = (r_q >> 1) ^ (r_q[0] ? LFSR_TAPS : '0);
  assign q     = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= SEED;
    end else if (step) begin
      r_q <= w_nxt;
    end
  end

endmodule

// File: rtl/ks_adder_bist.sv
// Self-test driver/checker for a 16-bit Kogge-Stone adder.
// Ports: clk, rst_n, start in; dut_a/dut_b out, dut_res in;
// busy, done, pass, err_count, first_fail_a/b/res status out.
module ks_adder_bist
  import ks_pkg::*;
#(
  parameter int              NUM_VECTORS = 256,
  parameter logic [KS_W-1:0] SEED_A      = 16'hACE1,
  parameter logic [KS_W-1:0] SEED_B      = 16'h1D2F,
  parameter int              ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [KS_W-1:0]  dut_a,
  output logic [KS_W-1:0]  dut_b,
  input  logic [KS_W-1:0]  dut_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [KS_W-1:0]  first_fail_a,
  output logic [KS_W-1:0]  first_fail_b,
  output logic [KS_W-1:0]  first_fail_res
);

  localparam int TOTAL = N_DIR + NUM_VECTORS;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TOTAL - 1);

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0] r_idx;
  logic             r_chk;
  logic             r_busy;
  logic             r_done;
  logic             r_hit;
  logic [ERR_W-1:0] r_err;
  logic [KS_W-1:0]  r_a;
  logic [KS_W-1:0]  r_b;
  logic [KS_W-1:0]  r_fa;
  logic [KS_W-1:0]  r_fb;
  logic [KS_W-1:0]  r_fr;

  logic            w_accept;
  logic            w_drive;
  logic            w_rand;
  logic            w_last;
  logic            w_mis;
  logic [KS_W-1:0] w_la;
  logic [KS_W-1:0] w_lb;
  logic [KS_W-1:0] w_va;
  logic [KS_W-1:0] w_vb;
  logic [KS_W-1:0] w_sum;
  vec_t            w_dir;

  assign w_accept = start &&
    (r_state == S_IDLE || r_state == S_DONE);
  assign w_drive  = (r_state == S_RUN);
  assign w_rand   = (r_idx >= IDX_W'(N_DIR));
  assign w_last   = (r_idx == LAST);
  assign w_dir    = dir_vec(r_idx[3:0]);
  assign w_va     = w_rand ? w_la : w_dir.a;
  assign w_vb     = w_rand ? w_lb : w_dir.b;

  // r_a/r_b are the operands currently on the adder inputs, so they
  // double as the registered copy the one-cycle-late check uses.
  assign w_sum = r_a + r_b;
  assign w_mis = r_chk && (dut_res != w_sum);

  ks_lfsr #(.SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .step  (w_drive && w_rand),
    .q     (w_la)
  );

  ks_lfsr #(.SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .step  (w_drive && w_rand),
    .q     (w_lb)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (w_accept) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_chk  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hit  <= 1'b0;
      r_err  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_fa   <= '0;
      r_fb   <= '0;
      r_fr   <= '0;
    end else begin
      r_busy <= (w_next == S_RUN) || (w_next == S_DRAIN);
      r_done <= (w_next == S_DONE);
      r_chk  <= w_drive;
      if (w_accept) begin
        r_idx <= '0;
        r_hit <= 1'b0;
        r_err <= '0;
        r_fa  <= '0;
        r_fb  <= '0;
        r_fr  <= '0;
      end else begin
        if (w_drive) begin
          r_a <= w_va;
          r_b <= w_vb;
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        if (w_mis) begin
          if (r_err != '1) r_err <= r_err + ERR_W'(1);
          if (!r_hit) begin
            r_hit <= 1'b1;
            r_fa  <= r_a;
            r_fb  <= r_b;
            r_fr  <= dut_res;
          end
        end
      end
    end
  end

  assign dut_a          = r_a;
  assign dut_b          = r_b;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_done && (r_err == '0);
  assign err_count      = r_err;
  assign first_fail_a   = r_fa;
  assign first_fail_b   = r_fb;
  assign first_fail_res = r_fr;

endmodule

// File: tb/tb_ks_adder_bist.sv
// Scoreboard bench for ks_adder_bist with a behavioural adder
// (good and faulty variants) on the dut_res side.
module tb_ks_adder_bist;

  localparam int NV = 256;

  typedef struct {
    int          blen;
    int          err;
    bit          pass;
    logic [15:0] fa;
    logic [15:0] fb;
    logic [15:0] fr;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic st0 = 1'b0;
  logic st1 = 1'b0;
  logic st2 = 1'b0;
  int   fm0 = 0;

  logic [15:0] a0, b0, res0, fa0, fb0, fr0, err0;
  logic        busy0, done0, pass0;
  logic [15:0] a1, b1, fa1, fb1, fr1;
  logic [3:0]  err1;
  logic        busy1, done1, pass1;
  logic [15:0] a2, b2, res2, fa2, fb2, fr2, err2;
  logic        busy2, done2, pass2;

  int errors = 0;
  int checks = 0;

  res_t        rq0[$];
  res_t        rq1[$];
  res_t        rq2[$];
  logic [31:0] vq0[$];

  int bc0 = 0, bc1 = 0, bc2 = 0;
  bit pd0 = 0, pd1 = 0, pd2 = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] add_f(input int fm,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [3:0]  lo;
    logic [11:0] hi;
    logic [15:0] s;
    s = a + b;
    case (fm)
      1: s = s & 16'hFFFE;
      2: begin
        lo = a[3:0] + b[3:0];
        hi = a[15:4] + b[15:4];
        s  = {hi, lo};
      end
      3: s = 16'h0000;
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  always_comb res0 = add_f(fm0, a0, b0);
  always_comb res2 = a2 + b2;

  ks_adder_bist #(.NUM_VECTORS(NV)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0),
    .dut_a(a0), .dut_b(b0), .dut_res(res0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_a(fa0),
    .first_fail_b(fb0), .first_fail_res(fr0)
  );

  ks_adder_bist #(.NUM_VECTORS(NV), .ERR_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1),
    .dut_a(a1), .dut_b(b1), .dut_res(16'h0000),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_a(fa1),
    .first_fail_b(fb1), .first_fail_res(fr1)
  );

  ks_adder_bist #(.NUM_VECTORS(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2),
    .dut_a(a2), .dut_b(b2), .dut_res(res2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_a(fa2),
    .first_fail_b(fb2), .first_fail_res(fr2)
  );

  // Reference: walk the whole vector list with plain arithmetic.
  task automatic model(input int nv, input int ew, input int fm,
                       input bit push_vec, output res_t r);
    logic [31:0] dirv [12];
    logic [15:0] la, lb, a, b, got, want;
    int          cnt, sat;
    bit          hit;
    dirv = '{32'h0000_0000, 32'h0000_0001, 32'h0002_0005,
             32'h000E_0001, 32'h000F_0001, 32'h0010_0001,
             32'h0011_0005, 32'h000F_0000, 32'h0010_0000,
             32'hFFFF_0001, 32'h7FFF_0001, 32'hFFFF_FFFF};
    r   = '{default: 0};
    la  = 16'hACE1;
    lb  = 16'h1D2F;
    cnt = 0;
    hit = 0;
    sat = (1 << ew) - 1;
    for (int i = 0; i < 12 + nv; i++) begin
      if (i < 12) begin
        a = dirv[i][31:16];
        b = dirv[i][15:0];
      end else begin
        a  = la;
        b  = lb;
        la = lfsr_nxt(la);
        lb = lfsr_nxt(lb);
      end
      if (push_vec) vq0.push_back({a, b});
      got  = add_f(fm, a, b);
      want = a + b;
      if (got != want) begin
        if (cnt < sat) cnt++;
        if (!hit) begin
          hit  = 1;
          r.fa = a;
          r.fb = b;
          r.fr = got;
        end
      end
    end
    r.blen = 13 + nv;
    r.err  = cnt;
    r.pass = (cnt == 0);
  endtask

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    res_t r;
    logic [31:0] e;
    if (!rst_n) begin
      chk("rst_u0", {a0, b0, busy0, done0, pass0, err0,
                     fa0, fb0, fr0}, '0);
      chk("rst_u1", {a1, b1, busy1, done1, pass1, err1,
                     fa1, fb1, fr1}, '0);
      chk("rst_u2", {a2, b2, busy2, done2, pass2, err2,
                     fa2, fb2, fr2}, '0);
      bc0 = 0; bc1 = 0; bc2 = 0;
      pd0 = 0; pd1 = 0; pd2 = 0;
    end else begin
      if (busy0) begin
        bc0++;
        if (bc0 >= 2) begin
          if (vq0.size() == 0) begin
            chk("u0_vec_extra", {a0, b0}, 'x);
          end else begin
            e = vq0.pop_front();
            chk("u0_vec", {a0, b0}, e);
          end
        end
      end
      if (busy1) bc1++;
      if (busy2) bc2++;
      if (done0 && !pd0) begin
        if (rq0.size() == 0) begin
          chk("u0_unexp_done", done0, 1'b0);
        end else begin
          r = rq0.pop_front();
          chk("u0_blen", bc0, r.blen);
          chk("u0_err", err0, r.err);
          chk("u0_pass", pass0, r.pass);
          chk("u0_ffail", {fa0, fb0, fr0}, {r.fa, r.fb, r.fr});
        end
        bc0 = 0;
      end
      if (done1 && !pd1) begin
        if (rq1.size() == 0) begin
          chk("u1_unexp_done", done1, 1'b0);
        end else begin
          r = rq1.pop_front();
          chk("u1_blen", bc1, r.blen);
          chk("u1_err_sat", err1, r.err);
          chk("u1_pass", pass1, r.pass);
          chk("u1_ffail", {fa1, fb1, fr1}, {r.fa, r.fb, r.fr});
        end
        bc1 = 0;
      end
      if (done2 && !pd2) begin
        if (rq2.size() == 0) begin
          chk("u2_unexp_done", done2, 1'b0);
        end else begin
          r = rq2.pop_front();
          chk("u2_blen", bc2, r.blen);
          chk("u2_err", err2, r.err);
          chk("u2_pass", pass2, r.pass);
          chk("u2_ffail", {fa2, fb2, fr2}, {r.fa, r.fb, r.fr});
        end
        bc2 = 0;
      end
      pd0 = done0;
      pd1 = done1;
      pd2 = done2;
    end
  end

  task automatic run0(input int fm, input int re_at, input bit others);
    res_t r;
    bit   ok;
    fm0 = fm;
    model(NV, 16, fm, 1'b1, r);
    rq0.push_back(r);
    if (others) begin
      model(NV, 4, 3, 1'b0, r);
      rq1.push_back(r);
      model(0, 16, 0, 1'b0, r);
      rq2.push_back(r);
    end
    @(posedge clk);
    #1;
    st0 = 1'b1;
    st1 = others;
    st2 = others;
    @(posedge clk);
    #1;
    st0 = 1'b0;
    st1 = 1'b0;
    st2 = 1'b0;
    ok = 0;
    for (int c = 1; c < 800; c++) begin
      @(posedge clk);
      #1;
      st0 = (c == re_at);
      if (done0 && !st0) begin
        ok = 1;
        break;
      end
    end
    st0 = 1'b0;
    if (!ok) begin
      $display("FAIL u0_timeout got=no_done want=done");
      $fatal(1, "run did not complete");
    end
    @(negedge clk);
  endtask

  initial begin
    res_t r;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run0(0, 0, 1'b1);
    run0(1, 0, 1'b0);
    run0(2, 0, 1'b0);
    run0(0, 10, 1'b0);

    fm0 = 0;
    model(NV, 16, 0, 1'b1, r);
    rq0.push_back(r);
    @(posedge clk);
    #1 st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    vq0.delete();
    rq0.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run0(0, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
